// File: rtl/module_bcd_entry_reg.sv
// module_bcd_entry_reg
//   Keypad digit-entry register. BCD digits are shifted in calculator-style,
//   with the newest digit least significant. Backspace, clear and a commit
//   handshake are supported. A commit publishes the entry on out.
//
//   Optional feature macro: BCD_ENTRY_BIN_EN
//     Defined:   a multicycle BCD-to-binary converter and the out_bin port are
//                added. out_vld pulses DIGITS+1 cycles after the commit edge.
//                busy is high while the conversion runs.
//     Undefined: there is no converter and busy is tied low. out_vld pulses
//                on the cycle after the commit edge.
//
//   Parameters
//     DIGITS     number of BCD digits held (1..8)
//   Ports
//     clk        system clock; all state changes on the rising edge
//     rst        synchronous active-low reset
//     digit_vld  strobe: a new digit is present on digit
//     digit      BCD digit value (0..9 are legal)
//     bksp       strobe: delete the newest digit
//     clr        strobe: discard the whole entry
//     commit     strobe: publish the entry
//     entry      live entry; digit 0 is in bits [3:0]
//     count      number of digits currently held
//     full       count == DIGITS
//     out        last committed BCD value
//     out_vld    one-cycle pulse: out (and out_bin) updated
//     err        one-cycle pulse: a request was rejected
//     busy       binary conversion in progress
//     out_bin    binary value of out (BCD_ENTRY_BIN_EN only)
//   Request priority: clr > commit > bksp > digit_vld. Requests that lose
//   the priority contest are dropped and do not raise err.
module module_bcd_entry_reg #(
  parameter int DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_vld,
  input  logic [3:0]                      digit,
  input  logic                            bksp,
  input  logic                            clr,
  input  logic                            commit,
  output logic [4*DIGITS-1:0]             entry,
  output logic [$clog2(DIGITS+1)-1:0]     count,
  output logic                            full,
  output logic [4*DIGITS-1:0]             out,
  output logic                            out_vld,
  output logic                            err,
  output logic                            busy
`ifdef BCD_ENTRY_BIN_EN
  ,
  output logic [$clog2(10**DIGITS)-1:0]   out_bin
`endif
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int EW = 4*DIGITS;

  logic [EW-1:0] entry_n;
  logic [CW-1:0] count_n;
  logic          err_n;
  logic          take;

  // Request arbitration and the next-state value of the entry.
  always_comb begin
    entry_n = entry;
    count_n = count;
    err_n   = 1'b0;
    take    = 1'b0;
    if (clr) begin
      entry_n = '0;
      count_n = '0;
    end else if (commit) begin
      if ((count != '0) && !busy) begin
        take    = 1'b1;
        entry_n = '0;
        count_n = '0;
      end else begin
        err_n = 1'b1;
      end
    end else if (bksp) begin
      if (count != '0) begin
        entry_n = entry >> 4;
        count_n = count - CW'(1);
      end else begin
        err_n = 1'b1;
      end
    end else if (digit_vld) begin
      // An illegal digit and a full register both end in one err pulse.
      if ((digit > 4'd9) || full) begin
        err_n = 1'b1;
      end else begin
        entry_n = (entry << 4) | EW'(digit);
        count_n = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entry <= '0;
      count <= '0;
      full  <= 1'b0;
      err   <= 1'b0;
      out   <= '0;
    end else begin
      entry <= entry_n;
      count <= count_n;
      full  <= (count_n == CW'(DIGITS));
      err   <= err_n;
      if (take) out <= entry;
    end
  end

`ifdef BCD_ENTRY_BIN_EN
  localparam int BW = $clog2(10**DIGITS);

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

  conv_state_t   state;
  logic [CW-1:0] step;
  logic [BW-1:0] acc;
  logic [BW-1:0] acc_nxt;
  logic [3:0]    dsel;

  // The conversion starts with the most significant digit. Each step reads
  // from out, which has been stable since the commit edge.
  assign dsel    = out[4*int'(step) +: 4];
  assign acc_nxt = acc * BW'(10) + BW'(dsel);
  assign busy    = (state == CONV_RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CONV_IDLE;
      step    <= '0;
      acc     <= '0;
      out_bin <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        CONV_IDLE: begin
          if (take) begin
            state <= CONV_RUN;
            step  <= CW'(DIGITS-1);
            acc   <= '0;
          end
        end
        CONV_RUN: begin
          acc <= acc_nxt;
          if (step == '0) begin
            out_bin <= acc_nxt;
            out_vld <= 1'b1;
            state   <= CONV_IDLE;
          end else begin
            step <= step - CW'(1);
          end
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) out_vld <= 1'b0;
    else      out_vld <= take;
  end
`endif

endmodule
